// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding.
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (LSB first, one bit per clock) with a
// start/busy/done handshake; results update only when an operation completes.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic [WIDTH-1:0] d_cat;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             brw_nxt;
    logic             d;
    logic             a_msb;
    logic             b_msb;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .diff (d),
        .bout (brw_nxt)
    );

    assign last  = (cnt == CNT_W'(WIDTH - 1));
    // Only WIDTH-1 earlier bits need storing; the final bit joins them at completion.
    assign d_cat = {d, d_sh};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // busy/done come straight from flops loaded with the next-state decode.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_SHIFT);
            done  <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            brw  <= brw_nxt;
            d_sh <= d_cat[WIDTH-1:1];
            cnt  <= cnt + CNT_W'(1);
            if (last) begin
                diff <= d_cat;
                bout <= brw_nxt;
                ovf  <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed, random and protocol scenarios.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int LIMIT = 50;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned arithmetic; result packed as {bout, ovf, diff}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mbin);
        logic [WIDTH:0] full;
        logic           v;
        full = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        v    = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return {full[WIDTH], v, full[WIDTH-1:0]};
    endfunction

    // Launch one operation, scramble the operand inputs while it runs, and
    // return the result seen in the done cycle plus handshake observations.
    task automatic do_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                         input logic op_bin, output logic [WIDTH+1:0] res,
                         output int busy_cyc, output bit done_one, output bit timeout);
        int cyc;
        @(negedge clk);
        a = op_a; b = op_b; bin = op_bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) busy_cyc++;
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        timeout = (cyc >= LIMIT);
        res = {bout, ovf, diff};
        @(negedge clk);
        done_one = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [4] = '{8'd100, 8'd5, 8'h80, 8'd0};
        logic [WIDTH-1:0] vb [4] = '{8'd37, 8'd10, 8'h01, 8'd0};
        logic             vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [WIDTH+1:0] want [4] = '{{2'b00, 8'd63}, {2'b10, 8'hFB}, {2'b01, 8'h7F}, {2'b10, 8'hFF}};
        logic [WIDTH+1:0] res;
        int  bc;
        bit  one, to;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], res, bc, one, to);
            n_vec++;
            if (to || res !== want[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got {bout,ovf,diff}=%b_%b_%h timeout=%0b, want %b_%b_%h",
                         i, res[9], res[8], res[7:0], to, want[i][9], want[i][8], want[i][7:0]);
            end
            n_vec++;
            if (bc != WIDTH || !one) begin
                n_err++;
                $display("FAIL directed_hs_%0d: got busy_cycles=%0d done_single=%0b, want %0d 1",
                         i, bc, one, WIDTH);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH+1:0] res, exp_res;
        int  bc;
        bit  one, to;
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
            exp_res = model(ra, rb, rc);
            do_op(ra, rb, rc, res, bc, one, to);
            n_vec++;
            if (to || res !== exp_res || bc != WIDTH || !one) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h bin=%b: got res=%h busy=%0d single=%0b to=%0b, want res=%h busy=%0d",
                         i, ra, rb, rc, res, bc, one, to, exp_res, WIDTH);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd9; b = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc >= LIMIT || {bout, ovf, diff} !== model(8'd100, 8'd37, 1'b0)) begin
            n_err++;
            $display("FAIL ignore_start: got diff=%0d bout=%b ovf=%b, want diff=63 bout=0 ovf=0",
                     diff, bout, ovf);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ra, rb;
        int cyc, bc;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom);
        @(negedge clk);
        a = ra; b = rb; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc >= LIMIT || {bout, ovf, diff} !== model(ra, rb, 1'b0)) begin
            n_err++;
            $display("FAIL b2b_first: got res=%h, want %h", {bout, ovf, diff}, model(ra, rb, 1'b0));
        end
        a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_no_gap: got busy=%b, want 1", busy);
        end
        cyc = 0; bc = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc >= LIMIT || bc != WIDTH || diff !== 8'd5 || bout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got diff=%0d bout=%b ovf=%b busy_cycles=%0d, want 5 0 0 %0d",
                     diff, bout, ovf, bc, WIDTH);
        end
    endtask

    task automatic test_async_reset();
        logic [WIDTH+1:0] res;
        int  bc;
        bit  one, to, saw_done;
        @(negedge clk);
        a = 8'd250; b = 8'd3; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || diff === '0) begin
            n_err++;
            $display("FAIL arst_precond: got busy=%b diff=%h, want busy=1 diff nonzero", busy, diff);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, diff, bout, ovf} !== '0) begin
            n_err++;
            $display("FAIL arst_immediate: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy, done, diff, bout, ovf);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL arst_no_done: got done/busy activity after reset=1, want 0");
        end
        do_op(8'd200, 8'd55, 1'b0, res, bc, one, to);
        n_vec++;
        if (to || res !== {2'b00, 8'd145} || bc != WIDTH || !one) begin
            n_err++;
            $display("FAIL arst_recover: got res=%h busy=%0d single=%0b to=%0b, want res=%h busy=%0d",
                     res, bc, one, to, {2'b00, 8'd145}, WIDTH);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
